// File: rtl/urp_pcie_rx_phy_deframer.sv
// urp_pcie_rx_phy_deframer: assembles 9-beat lane frames into a 268-bit TLP word,
// flags malformed frames with a pulse and a saturating error count.
module urp_pcie_rx_phy_deframer #(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          lane_data_i,
  input  logic                 lane_sop_i,
  input  logic                 lane_eop_i,
  input  logic                 lane_valid_i,
  output logic                 lane_ready_o,
  output logic [267:0]         tlp_data_o,
  output logic                 tlp_valid_o,
  input  logic                 tlp_ready_i,
  output logic                 frame_err_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  state_t               r_state;
  logic [3:0]           r_cnt;
  logic [267:0]         r_data;
  logic                 r_ready;
  logic                 r_valid;
  logic                 r_err;
  logic [ERR_CNT_W-1:0] r_err_cnt;
  logic                 w_beat;
  logic                 w_last;
  logic                 w_err;
  logic [8:0]           w_base;
  assign w_beat = lane_valid_i & r_ready;
  assign w_last = r_cnt == 4'd8;
  assign w_base = 9'd267 - {r_cnt, 5'd0};
  // A COLLECT beat is bad if it restarts a frame or its eop disagrees with the beat position
  always_comb begin
    w_err = w_beat && (r_state == IDLE    ? (!lane_sop_i || lane_eop_i) :
                       r_state == COLLECT ? (lane_sop_i || (w_last ? !lane_eop_i : lane_eop_i)) :
                                            1'b0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= 4'd0;
      r_data    <= '0;
      r_ready   <= 1'b0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_err <= w_err;
      if (w_err && !(&r_err_cnt)) r_err_cnt <= r_err_cnt + 1'b1;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (w_beat && lane_sop_i && !lane_eop_i) begin
            r_data[267:236] <= lane_data_i;
            r_cnt           <= 4'd1;
            r_state         <= COLLECT;
          end
        end
        COLLECT: begin
          if (w_beat) begin
            if (lane_sop_i) begin
              r_data[267:236] <= lane_data_i;
              r_cnt           <= 4'd1;
            end else if (w_err) begin
              r_cnt   <= 4'd0;
              r_state <= IDLE;
            end else if (w_last) begin
              r_data[11:0] <= lane_data_i[11:0];
              r_cnt        <= 4'd0;
              r_state      <= HOLD;
              r_valid      <= 1'b1;
              r_ready      <= 1'b0;
            end else begin
              r_data[w_base -: 32] <= lane_data_i;
              r_cnt                <= r_cnt + 4'd1;
            end
          end
        end
        HOLD: begin
          if (tlp_ready_i) begin
            r_state <= IDLE;
            r_valid <= 1'b0;
            r_ready <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign lane_ready_o = r_ready;
  assign tlp_data_o   = r_data;
  assign tlp_valid_o  = r_valid;
  assign frame_err_o  = r_err;
  assign err_cnt_o    = r_err_cnt;
endmodule

// File: tb/tb_urp_pcie_rx_phy_deframer.sv
// tb_urp_pcie_rx_phy_deframer: directed and random frames checked against a
// frame-level reference model (word list per frame, expected error count).
module tb_urp_pcie_rx_phy_deframer;
  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic [31:0]  lane_data_i = '0;
  logic         lane_sop_i = 1'b0;
  logic         lane_eop_i = 1'b0;
  logic         lane_valid_i = 1'b0;
  logic         lane_ready_o;
  logic [267:0] tlp_data_o;
  logic         tlp_valid_o;
  logic         tlp_ready_i = 1'b0;
  logic         frame_err_o;
  logic [7:0]   err_cnt_o;

  urp_pcie_rx_phy_deframer #(.ERR_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .lane_data_i(lane_data_i), .lane_sop_i(lane_sop_i),
    .lane_eop_i(lane_eop_i), .lane_valid_i(lane_valid_i), .lane_ready_o(lane_ready_o),
    .tlp_data_o(tlp_data_o), .tlp_valid_o(tlp_valid_o), .tlp_ready_i(tlp_ready_i),
    .frame_err_o(frame_err_o), .err_cnt_o(err_cnt_o)
  );

  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;
  logic [31:0]  m_words[$];
  bit           m_in, m_hold, m_ready, m_valid, m_err;
  int           m_cnt;
  logic [267:0] m_data;
  bit           tr_rand = 1'b0;
  bit           tr_fixed = 1'b1;

  task automatic chk(input string tag, input logic [267:0] obs, input logic [267:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_words.delete();
    m_in = 0; m_hold = 0; m_ready = 0; m_valid = 0; m_err = 0; m_cnt = 0; m_data = '0;
  endtask

  task automatic flag_err();
    m_err = 1;
    if (m_cnt < 255) m_cnt++;
  endtask

  // Frame rules: sop starts a frame, exactly 9 words, eop only on the 9th.
  task automatic model_beat(input logic [31:0] d, input logic s, input logic e);
    if (s) begin
      if (m_in) flag_err();
      else if (e) begin
        flag_err();
        return;
      end
      m_words = {d};
      m_in = 1;
    end else if (!m_in) flag_err();
    else begin
      m_words.push_back(d);
      if (m_words.size() == 9) begin
        m_in = 0;
        if (e) begin
          m_data = {m_words[0], m_words[1], m_words[2], m_words[3], m_words[4],
                    m_words[5], m_words[6], m_words[7], m_words[8][11:0]};
          m_hold = 1;
        end else flag_err();
      end else if (e) begin
        m_in = 0;
        flag_err();
      end
    end
  endtask

  task automatic step(input logic v, input logic s, input logic e, input logic [31:0] d, input logic tr);
    bit beat;
    lane_valid_i = v; lane_sop_i = s; lane_eop_i = e; lane_data_i = d; tlp_ready_i = tr;
    beat = v && m_ready;
    @(posedge clk);
    #1;
    m_err = 0;
    if (m_hold) begin
      if (tr) m_hold = 0;
    end else if (beat) model_beat(d, s, e);
    m_ready = !m_hold;
    m_valid = m_hold;
    chk("lane_ready", {267'b0, lane_ready_o}, {267'b0, m_ready});
    chk("tlp_valid", {267'b0, tlp_valid_o}, {267'b0, m_valid});
    chk("frame_err", {267'b0, frame_err_o}, {267'b0, m_err});
    chk("err_cnt", {260'b0, err_cnt_o}, 268'(m_cnt));
    if (m_valid) chk("tlp_data", tlp_data_o, m_data);
  endtask

  function automatic logic cur_tr();
    return tr_rand ? logic'($urandom_range(0, 1)) : tr_fixed;
  endfunction

  task automatic send(input logic [31:0] d, input logic s, input logic e);
    int n = 0;
    bit acc;
    do begin
      acc = m_ready;
      step(1'b1, s, e, d, cur_tr());
      n++;
    end while (!acc && n < 200);
    chk("send_accept", {267'b0, acc}, 268'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom, cur_tr());
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, {267'b0, lane_ready_o}, '0);
    chk({tag, "_valid"}, {267'b0, tlp_valid_o}, '0);
    chk({tag, "_err"}, {267'b0, frame_err_o}, '0);
    chk({tag, "_cnt"}, {260'b0, err_cnt_o}, '0);
    chk({tag, "_data"}, tlp_data_o, '0);
  endtask

  initial begin
    model_reset();
    #1 rst_n = 1'b0;
    #1 chk_zero("reset");
    @(posedge clk);
    #1 chk_zero("reset_clk");
    rst_n = 1'b1;
    idle(1);
    // Basic frame, sink always ready
    for (int i = 1; i <= 9; i++) send(32'(i), i == 1, i == 9);
    chk("f1_word0", {236'b0, tlp_data_o[267:236]}, 268'h1);
    chk("f1_word7", {236'b0, tlp_data_o[43:12]}, 268'h8);
    chk("f1_tail", {256'b0, tlp_data_o[11:0]}, 268'h009);
    idle(2);
    // Backpressure: sink stalls for 5 cycles
    tr_fixed = 1'b0;
    for (int i = 1; i <= 9; i++) send(32'(i), i == 1, i == 9);
    idle(5);
    tr_fixed = 1'b1;
    idle(2);
    // Early eop on the 5th beat, then a clean frame
    for (int i = 1; i <= 5; i++) send(32'h10 + 32'(i), i == 1, i == 5);
    chk("early_eop_pulse", {267'b0, frame_err_o}, 268'd1);
    chk("early_eop_cnt", {260'b0, err_cnt_o}, 268'd1);
    for (int i = 1; i <= 9; i++) send(32'hA5A5_0000 + 32'(i), i == 1, i == 9);
    idle(1);
    // Restart: sop on 4th beat followed by 8 more beats
    for (int i = 1; i <= 12; i++) send(32'hC000_0000 + 32'(i), i == 1 || i == 4, i == 12);
    chk("restart_cnt", {260'b0, err_cnt_o}, 268'd2);
    idle(2);
    // Random frames: mostly well-formed, random gaps and sink backpressure
    tr_rand = 1'b1;
    for (int f = 0; f < 150; f++) begin
      int len;
      bit no_sop, no_eop;
      len = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 11)) : 9;
      no_sop = $urandom_range(0, 7) == 0;
      no_eop = $urandom_range(0, 7) == 0;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        send($urandom, i == 0 && !no_sop, i == len - 1 && !no_eop);
      end
      idle(int'($urandom_range(0, 2)));
    end
    tr_rand = 1'b0;
    tr_fixed = 1'b1;
    idle(2);
    // Saturation: 256 stray beats without sop
    for (int i = 0; i < 256; i++) send($urandom, 1'b0, 1'b0);
    idle(1);
    chk("sat_cnt", {260'b0, err_cnt_o}, 268'd255);
    send(32'h0, 1'b0, 1'b0);
    chk("sat_hold", {260'b0, err_cnt_o}, 268'd255);
    idle(1);
    // Reset during beat 6 of a frame
    for (int i = 1; i <= 5; i++) send(32'hD000_0000 + 32'(i), i == 1, 1'b0);
    lane_valid_i = 1'b1; lane_data_i = 32'hD000_0006; lane_sop_i = 1'b0; lane_eop_i = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("midrst");
    model_reset();
    @(posedge clk);
    #1 chk_zero("midrst_clk");
    rst_n = 1'b1;
    idle(1);
    for (int i = 1; i <= 9; i++) send(32'hE000_0000 + 32'(i), i == 1, i == 9);
    chk("post_rst_cnt", {260'b0, err_cnt_o}, 268'd0);
    idle(2);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/urp_pcie_rx_phy_deframer.md
URP_PCIE_RX_PHY_DEFRAMER -- requirements
Module: urp_pcie_rx_phy_deframer

Interface
REQ-001 SHALL have parameter ERR_CNT_W, default 8: width of the saturating frame-error counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 SHALL have port lane_data_i  input  32  de-scrambled symbol word from the physical layer.
REQ-005 SHALL have port lane_sop_i  input  1  marks the first word of a frame.
REQ-006 SHALL have port lane_eop_i  input  1  marks the last word of a frame.
REQ-007 SHALL have port lane_valid_i  input  1  lane word valid.
REQ-008 SHALL have port lane_ready_o  output  1  deframer can accept a lane word.
REQ-009 SHALL have port tlp_data_o  output  268  packed frame {TLP 224b, seq 12b, LCRC 32b} to the RX data link layer.
REQ-010 SHALL have port tlp_valid_o  output  1  tlp_data_o holds a complete frame.
REQ-011 SHALL have port tlp_ready_i  input  1  data link layer accepts the frame.
REQ-012 SHALL have port frame_err_o  output  1  one-cycle pulse per malformed frame.
REQ-013 SHALL have port err_cnt_o  output  ERR_CNT_W  saturating count of malformed frames.

Function
REQ-014 SHALL transfer a lane word only on a cycle where lane_valid_i and lane_ready_o are both 1 (a "beat").
REQ-015 SHALL transfer a frame only on a cycle where tlp_valid_o and tlp_ready_i are both 1.
REQ-016 SHALL form a frame from exactly 9 beats: beats 0..7 fill tlp_data_o[267-32k -: 32] for k=0..7; beat 8 fills tlp_data_o[11:0] from lane_data_i[11:0], lane_data_i[31:12] ignored.
REQ-017 SHALL implement states IDLE, COLLECT, HOLD with a 4-bit beat counter (0..8).
REQ-018 IDLE: lane_ready_o=1; beat with sop=1, eop=0 -> store as beat 0, counter=1, go COLLECT.
REQ-019 IDLE: beat with sop=0 -> discard, pulse frame_err_o, stay IDLE; beat with sop=1 and eop=1 -> discard, pulse frame_err_o, stay IDLE.
REQ-020 COLLECT: lane_ready_o=1; beat with sop=1 -> pulse frame_err_o, drop partial frame, store this word as beat 0, counter=1, stay COLLECT.
REQ-021 COLLECT, counter<8: beat with eop=1 -> pulse frame_err_o, go IDLE; otherwise store beat, counter+1.
REQ-022 COLLECT, counter=8: beat with eop=1 -> store beat 8, go HOLD; eop=0 -> pulse frame_err_o, go IDLE.
REQ-023 HOLD: lane_ready_o=0, tlp_valid_o=1; on tlp_ready_i=1 go IDLE; lane_ready_o returns to 1 the following cycle.
REQ-024 tlp_valid_o SHALL rise the cycle after the 9th beat is accepted (1-cycle latency) and tlp_data_o SHALL stay constant while tlp_valid_o=1.
REQ-025 tlp_valid_o SHALL be 0 in IDLE and COLLECT; minimum frame period is 10 cycles.
REQ-026 frame_err_o SHALL be a registered pulse, high exactly one cycle after the offending beat; err_cnt_o SHALL increment by 1 in that same cycle and hold at all-ones once saturated.
REQ-027 Cycles with lane_valid_i=0 SHALL not change state, counter or data in any state.

Reset
REQ-028 While rst_n=0: state=IDLE, counter=0, tlp_data_o=0, tlp_valid_o=0, lane_ready_o=0, frame_err_o=0, err_cnt_o=0.
REQ-029 First rising clk after rst_n deasserts SHALL drive lane_ready_o=1; reset mid-frame or in HOLD SHALL discard the frame with no frame_err_o pulse.

Verification
REQ-030 9 beats 0x0000_0001..0x0000_0009 (sop on 1st, eop on 9th), tlp_ready_i=1 -> tlp_valid_o high one cycle, tlp_data_o[267:236]=0x1, tlp_data_o[43:12]=0x8, tlp_data_o[11:0]=0x009.
REQ-031 Same frame with tlp_ready_i=0 for 5 cycles -> lane_ready_o=0, tlp_valid_o=1, data stable for 5 cycles; release -> lane_ready_o=1 next cycle.
REQ-032 eop on 5th beat -> frame_err_o pulse, err_cnt_o=1, no tlp_valid_o; next good frame delivered intact.
REQ-033 sop on 4th beat followed by 8 more beats ending in eop -> one error pulse, frame built from the restarting beat delivered.
REQ-034 256 malformed frames with ERR_CNT_W=8 -> err_cnt_o saturates at 255.
REQ-035 rst_n low during beat 6 -> all outputs 0; after release a complete frame is delivered correctly, err_cnt_o=0.
